usm_rd_credit_limiter: RTL and testbench

- Avalon-MM responder/initiator pair between the kernel-side USM (SVM) host port and the host-channel clock-crossing bridge.
- Accepts kernel read and write bursts on its responder side and forwards them registered to the host side.
- Counts outstanding read beats and backpressures new reads so the CCB response FIFO never overflows.
- Returns read data to the kernel with one cycle of registered latency.

---
 rtl/usm_rd_credit_limiter_pkg.sv | 22 ++
 rtl/usm_rd_credit_ctr.sv | 62 ++++++
 rtl/usm_rd_credit_limiter.sv | 170 +++++++++++++++++
 tb/tb_usm_rd_credit_limiter.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/usm_rd_credit_limiter_pkg.sv
// Shared BSP constants and the command-register type for the USM host-port read credit limiter.
// Struct fields are sized for the widest supported configuration; narrower builds zero-extend into them.
package usm_rd_credit_limiter_pkg;

    localparam int OPENCL_SVM_QSYS_ADDR_WIDTH         = 48;
    localparam int OPENCL_BSP_KERNEL_SVM_DATA_WIDTH   = 512;
    localparam int OPENCL_BSP_KERNEL_SVM_BE_WIDTH     = OPENCL_BSP_KERNEL_SVM_DATA_WIDTH / 8;
    localparam int OPENCL_BSP_KERNEL_SVM_BURST_WIDTH  = 5;
    localparam int USM_CCB_RESPONSE_FIFO_DEPTH        = 256;

    localparam logic [0:0] BURST_IDLE = 1'b0;
    localparam logic [0:0] BURST_WR   = 1'b1;

    typedef struct packed {
        logic [OPENCL_SVM_QSYS_ADDR_WIDTH-1:0]        addr;
        logic [OPENCL_BSP_KERNEL_SVM_DATA_WIDTH-1:0]  wdata;
        logic [OPENCL_BSP_KERNEL_SVM_BE_WIDTH-1:0]    be;
        logic [OPENCL_BSP_KERNEL_SVM_BURST_WIDTH-1:0] bc;
        logic                                         is_wr;
    } usm_cmd_t;

endpackage

// File: rtl/usm_rd_credit_ctr.sv
// Outstanding read-beat credit counter with overflow block compare and sticky underflow flag.
// Kept standalone so the second host channel can reuse it.
module usm_rd_credit_ctr #(
    parameter int MAX_OUTSTANDING = 256,
    parameter int BURST_W         = 5,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_req,
    input  logic               rd_acc,
    input  logic [BURST_W-1:0] bc,
    input  logic               rsp_vld,
    output logic [CNT_W-1:0]   count,
    output logic               rd_block,
    output logic               err_underflow
);

    localparam int SUM_W = ((CNT_W > BURST_W) ? CNT_W : BURST_W) + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [SUM_W-1:0] bc_eff, cnt_ext, max_ext, nxt;
    logic             rsp_underflow;

    assign bc_eff        = (bc == '0) ? SUM_W'(1) : SUM_W'(bc);
    assign cnt_ext       = SUM_W'(count_q);
    assign max_ext       = SUM_W'(MAX_OUTSTANDING);
    assign rsp_underflow = rsp_vld & (count_q == '0);

    // Block decision uses the registered count only: a release this cycle frees credit next cycle.
    assign rd_block = rd_req & ((cnt_ext + bc_eff) > max_ext);

    always_comb begin
        nxt = cnt_ext;
        if (rd_acc) begin
            nxt = nxt + bc_eff;
        end
        if (rsp_vld && !rsp_underflow) begin
            nxt = nxt - SUM_W'(1);
        end
        if (nxt > max_ext) begin
            nxt = max_ext;
        end
        count_d = CNT_W'(nxt);
        err_d   = err_q | rsp_underflow;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    assign count         = count_q;
    assign err_underflow = err_q;

endmodule

// File: rtl/usm_rd_credit_limiter.sv
// Kernel USM port to host-channel CCB bridge: registered command stage, write-burst tracking and
// read-credit backpressure. Optional statistics enabled by USM_RD_LIMIT_STATS_EN.
module usm_rd_credit_limiter
    import usm_rd_credit_limiter_pkg::*;
#(
    parameter int ADDR_W          = OPENCL_SVM_QSYS_ADDR_WIDTH,
    parameter int DATA_W          = OPENCL_BSP_KERNEL_SVM_DATA_WIDTH,
    parameter int BE_W            = OPENCL_BSP_KERNEL_SVM_BE_WIDTH,
    parameter int BURST_W         = OPENCL_BSP_KERNEL_SVM_BURST_WIDTH,
    parameter int MAX_OUTSTANDING = USM_CCB_RESPONSE_FIFO_DEPTH
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic [ADDR_W-1:0]                      s_address,
    input  logic                                   s_read,
    input  logic                                   s_write,
    input  logic [DATA_W-1:0]                      s_writedata,
    input  logic [BE_W-1:0]                        s_byteenable,
    input  logic [BURST_W-1:0]                     s_burstcount,
    output logic                                   s_waitrequest,
    output logic [DATA_W-1:0]                      s_readdata,
    output logic                                   s_readdatavalid,
    output logic [ADDR_W-1:0]                      m_address,
    output logic                                   m_read,
    output logic                                   m_write,
    output logic [DATA_W-1:0]                      m_writedata,
    output logic [BE_W-1:0]                        m_byteenable,
    output logic [BURST_W-1:0]                     m_burstcount,
    input  logic                                   m_waitrequest,
    input  logic [DATA_W-1:0]                      m_readdata,
    input  logic                                   m_readdatavalid,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   outstanding_beats,
    output logic                                   err_underflow
`ifdef USM_RD_LIMIT_STATS_EN
    ,
    output logic [$clog2(MAX_OUTSTANDING+1)-1:0]   peak_outstanding,
    output logic [31:0]                            stall_cycles
`endif
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

    usm_cmd_t             cmd_q, cmd_d;
    logic                 cmd_valid_q, cmd_valid_d;
    logic [0:0]           state_q, state_d;
    logic [BURST_W-1:0]   remaining_q, remaining_d;
    logic [DATA_W-1:0]    rdata_q;
    logic                 rvalid_q;

    logic                 stall_cmd, rd_hold, rd_block, rd_req;
    logic                 rd_acc, wr_acc, accept;
    logic [BURST_W-1:0]   wr_bc;
    logic [CNT_W-1:0]     count;

    assign stall_cmd     = cmd_valid_q & m_waitrequest;
    assign rd_hold       = s_read & (state_q == BURST_WR);
    assign rd_req        = s_read & (state_q == BURST_IDLE);
    assign s_waitrequest = stall_cmd | rd_block | rd_hold;

    // A read presented together with a write takes priority; the write is dropped.
    assign rd_acc = s_read & ~s_waitrequest;
    assign wr_acc = s_write & ~s_read & ~s_waitrequest;
    assign accept = rd_acc | wr_acc;
    assign wr_bc  = (s_burstcount == '0) ? BURST_W'(1) : s_burstcount;

    usm_rd_credit_ctr #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING),
        .BURST_W         (BURST_W),
        .CNT_W           (CNT_W)
    ) u_credit_ctr (
        .clk           (clk),
        .reset         (reset),
        .rd_req        (rd_req),
        .rd_acc        (rd_acc),
        .bc            (s_burstcount),
        .rsp_vld       (m_readdatavalid),
        .count         (count),
        .rd_block      (rd_block),
        .err_underflow (err_underflow)
    );

    always_comb begin
        cmd_d       = cmd_q;
        cmd_valid_d = cmd_valid_q;
        if (accept) begin
            cmd_d.addr  = OPENCL_SVM_QSYS_ADDR_WIDTH'(s_address);
            cmd_d.wdata = OPENCL_BSP_KERNEL_SVM_DATA_WIDTH'(s_writedata);
            cmd_d.be    = OPENCL_BSP_KERNEL_SVM_BE_WIDTH'(s_byteenable);
            cmd_d.bc    = OPENCL_BSP_KERNEL_SVM_BURST_WIDTH'(s_burstcount);
            cmd_d.is_wr = wr_acc;
            cmd_valid_d = 1'b1;
        end else if (!m_waitrequest) begin
            cmd_valid_d = 1'b0;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        if (state_q == BURST_IDLE) begin
            if (wr_acc && (wr_bc > BURST_W'(1))) begin
                remaining_d = wr_bc - BURST_W'(1);
                state_d     = BURST_WR;
            end
        end else if (wr_acc) begin
            remaining_d = remaining_q - BURST_W'(1);
            if (remaining_q == BURST_W'(1)) begin
                state_d = BURST_IDLE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cmd_q       <= '0;
            cmd_valid_q <= 1'b0;
            state_q     <= BURST_IDLE;
            remaining_q <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
        end else begin
            cmd_q       <= cmd_d;
            cmd_valid_q <= cmd_valid_d;
            state_q     <= state_d;
            remaining_q <= remaining_d;
            rdata_q     <= m_readdata;
            rvalid_q    <= m_readdatavalid;
        end
    end

    assign m_read            = cmd_valid_q & ~cmd_q.is_wr;
    assign m_write           = cmd_valid_q & cmd_q.is_wr;
    assign m_address         = ADDR_W'(cmd_q.addr);
    assign m_writedata       = DATA_W'(cmd_q.wdata);
    assign m_byteenable      = BE_W'(cmd_q.be);
    assign m_burstcount      = BURST_W'(cmd_q.bc);
    assign s_readdata        = rdata_q;
    assign s_readdatavalid   = rvalid_q;
    assign outstanding_beats = count;

`ifdef USM_RD_LIMIT_STATS_EN
    logic [CNT_W-1:0] peak_q, peak_d;
    logic [31:0]      stall_q, stall_d;

    always_comb begin
        peak_d  = (count > peak_q) ? count : peak_q;
        stall_d = stall_q;
        if (rd_block && (stall_q != '1)) begin
            stall_d = stall_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            peak_q  <= '0;
            stall_q <= '0;
        end else begin
            peak_q  <= peak_d;
            stall_q <= stall_d;
        end
    end

    assign peak_outstanding = peak_q;
    assign stall_cycles     = stall_q;
`endif

    // Kernel must never present a read and a write in the same cycle.
    a_no_rd_wr_overlap : assert property (@(posedge clk) disable iff (reset) !(s_read && s_write));

endmodule

// File: tb/tb_usm_rd_credit_limiter.sv
// Directed bench for usm_rd_credit_limiter: vector table plus multi-cycle corner sequences.
module tb_usm_rd_credit_limiter;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [47:0]  s_address = '0;
    logic         s_read = 1'b0;
    logic         s_write = 1'b0;
    logic [511:0] s_writedata = '0;
    logic [63:0]  s_byteenable = '0;
    logic [4:0]   s_burstcount = '0;
    logic         s_waitrequest;
    logic [511:0] s_readdata;
    logic         s_readdatavalid;
    logic [47:0]  m_address;
    logic         m_read;
    logic         m_write;
    logic [511:0] m_writedata;
    logic [63:0]  m_byteenable;
    logic [4:0]   m_burstcount;
    logic         m_waitrequest = 1'b0;
    logic [511:0] m_readdata = '0;
    logic         m_readdatavalid = 1'b0;
    logic [8:0]   outstanding_beats;
    logic         err_underflow;
`ifdef USM_RD_LIMIT_STATS_EN
    logic [8:0]   peak_outstanding;
    logic [31:0]  stall_cycles;
`endif

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    usm_rd_credit_limiter dut (
        .clk               (clk),
        .reset             (reset),
        .s_address         (s_address),
        .s_read            (s_read),
        .s_write           (s_write),
        .s_writedata       (s_writedata),
        .s_byteenable      (s_byteenable),
        .s_burstcount      (s_burstcount),
        .s_waitrequest     (s_waitrequest),
        .s_readdata        (s_readdata),
        .s_readdatavalid   (s_readdatavalid),
        .m_address         (m_address),
        .m_read            (m_read),
        .m_write           (m_write),
        .m_writedata       (m_writedata),
        .m_byteenable      (m_byteenable),
        .m_burstcount      (m_burstcount),
        .m_waitrequest     (m_waitrequest),
        .m_readdata        (m_readdata),
        .m_readdatavalid   (m_readdatavalid),
        .outstanding_beats (outstanding_beats),
        .err_underflow     (err_underflow)
`ifdef USM_RD_LIMIT_STATS_EN
        ,
        .peak_outstanding  (peak_outstanding),
        .stall_cycles      (stall_cycles)
`endif
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [4:0]  bc;
        logic [47:0] addr;
        logic        mw;
        logic        rdv;
        logic [15:0] rdata;
        logic        e_sw;
        logic        e_mrd;
        logic        e_mwr;
        logic [47:0] e_addr;
        logic [8:0]  e_beats;
        logic        e_srdv;
        logic        e_err;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        s_read = 1'b0;
        s_write = 1'b0;
        s_address = '0;
        s_writedata = '0;
        s_byteenable = '0;
        s_burstcount = '0;
        m_waitrequest = 1'b0;
        m_readdatavalid = 1'b0;
        m_readdata = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic issue_read(input logic [4:0] bc, input logic [47:0] addr);
        s_read = 1'b1;
        s_burstcount = bc;
        s_address = addr;
        tick();
        s_read = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        //         rd wr bc  addr     mw rdv rdata  | sw mrd mwr e_addr   beats srdv err
        vecs[0] = '{0, 0, 0, 48'h0,   0, 0, 16'h0,    0, 0, 0, 48'h0,   9'd0, 0, 0};
        vecs[1] = '{1, 0, 4, 48'h100, 0, 0, 16'h0,    0, 1, 0, 48'h100, 9'd4, 0, 0};
        vecs[2] = '{1, 0, 0, 48'h200, 0, 0, 16'h0,    0, 1, 0, 48'h200, 9'd5, 0, 0};
        vecs[3] = '{0, 0, 0, 48'h0,   0, 1, 16'hAA,   0, 0, 0, 48'h0,   9'd4, 1, 0};
        vecs[4] = '{1, 0, 4, 48'h300, 0, 1, 16'hBB,   0, 1, 0, 48'h300, 9'd7, 1, 0};
        vecs[5] = '{0, 1, 1, 48'h400, 0, 0, 16'h0,    0, 0, 1, 48'h400, 9'd7, 0, 0};
        vecs[6] = '{0, 0, 0, 48'h0,   1, 0, 16'h0,    1, 0, 1, 48'h400, 9'd7, 0, 0};
        vecs[7] = '{0, 0, 0, 48'h0,   0, 0, 16'h0,    0, 0, 0, 48'h0,   9'd7, 0, 0};

        do_reset();
        chk("rst_m_read", m_read, 0);
        chk("rst_m_write", m_write, 0);
        chk("rst_m_address", m_address, 0);
        chk("rst_m_writedata", m_writedata[63:0], 0);
        chk("rst_m_byteenable", m_byteenable, 0);
        chk("rst_m_burstcount", m_burstcount, 0);
        chk("rst_s_rdv", s_readdatavalid, 0);
        chk("rst_s_readdata", s_readdata[63:0], 0);
        chk("rst_outstanding", outstanding_beats, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_swait", s_waitrequest, 0);

        for (int i = 0; i < 8; i++) begin
            s_read = vecs[i].rd;
            s_write = vecs[i].wr;
            s_burstcount = vecs[i].bc;
            s_address = vecs[i].addr;
            m_waitrequest = vecs[i].mw;
            m_readdatavalid = vecs[i].rdv;
            m_readdata = '0;
            m_readdata[15:0] = vecs[i].rdata;
            #1;
            chk($sformatf("vec%0d_swait", i), s_waitrequest, vecs[i].e_sw);
            tick();
            chk($sformatf("vec%0d_m_read", i), m_read, vecs[i].e_mrd);
            chk($sformatf("vec%0d_m_write", i), m_write, vecs[i].e_mwr);
            if (vecs[i].e_mrd || vecs[i].e_mwr)
                chk($sformatf("vec%0d_m_address", i), m_address, vecs[i].e_addr);
            chk($sformatf("vec%0d_outstanding", i), outstanding_beats, vecs[i].e_beats);
            chk($sformatf("vec%0d_s_rdv", i), s_readdatavalid, vecs[i].e_srdv);
            if (vecs[i].e_srdv)
                chk($sformatf("vec%0d_s_readdata", i), s_readdata[15:0], vecs[i].rdata);
            chk($sformatf("vec%0d_err", i), err_underflow, vecs[i].e_err);
        end
        idle_inputs();

        // Fill to 256 with sixteen 16-beat reads, then a 17th waits for 16 returned beats.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            s_read = 1'b1;
            s_burstcount = 5'd16;
            s_address = 48'(i * 64);
            #1;
            chk($sformatf("fill%0d_swait", i), s_waitrequest, 0);
            tick();
        end
        chk("fill_outstanding", outstanding_beats, 9'd256);
        s_address = 48'h999;
        for (int k = 0; k < 16; k++) begin
            m_readdatavalid = 1'b1;
            #1;
            chk($sformatf("full_block%0d", k), s_waitrequest, 1);
            tick();
        end
        m_readdatavalid = 1'b0;
        chk("drain_outstanding", outstanding_beats, 9'd240);
        #1;
        chk("refill_swait", s_waitrequest, 0);
        tick();
        s_read = 1'b0;
        chk("refill_outstanding", outstanding_beats, 9'd256);
        chk("refill_m_read", m_read, 1);
        chk("refill_m_address", m_address, 48'h999);

        // Boundary: 250 outstanding, bc=6 fits exactly, then bc=1 and bc=0 do not.
        do_reset();
        for (int i = 0; i < 15; i++) issue_read(5'd16, 48'h0);
        issue_read(5'd10, 48'h0);
        chk("bnd_start", outstanding_beats, 9'd250);
        s_read = 1'b1;
        s_burstcount = 5'd6;
        #1;
        chk("bnd_bc6_swait", s_waitrequest, 0);
        tick();
        chk("bnd_bc6_outstanding", outstanding_beats, 9'd256);
        s_burstcount = 5'd1;
        #1;
        chk("bnd_bc1_swait", s_waitrequest, 1);
        tick();
        chk("bnd_bc1_outstanding", outstanding_beats, 9'd256);
        s_burstcount = 5'd0;
        #1;
        chk("bnd_bc0_swait", s_waitrequest, 1);
        s_read = 1'b0;

        // Accept and release in the same cycle.
        do_reset();
        issue_read(5'd10, 48'h0);
        s_read = 1'b1;
        s_burstcount = 5'd4;
        m_readdatavalid = 1'b1;
        #1;
        chk("net_swait", s_waitrequest, 0);
        tick();
        s_read = 1'b0;
        m_readdatavalid = 1'b0;
        chk("net_outstanding", outstanding_beats, 9'd13);

        // 8-beat write burst with a read attempted between beats 4 and 5.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            if (i == 4) begin
                for (int g = 0; g < 2; g++) begin
                    s_write = 1'b0;
                    s_read = 1'b1;
                    s_burstcount = 5'd2;
                    s_address = 48'h7000;
                    #1;
                    chk($sformatf("wrb_rd_hold%0d", g), s_waitrequest, 1);
                    tick();
                    chk($sformatf("wrb_hold_outstanding%0d", g), outstanding_beats, 0);
                end
                s_read = 1'b0;
            end
            s_write = 1'b1;
            s_address = 48'h4000;
            s_burstcount = 5'd8;
            s_writedata = '0;
            s_writedata[63:0] = 64'h1000 + 64'(i);
            s_byteenable = 64'hFFFF_0000_FFFF_0000;
            #1;
            chk($sformatf("wrb%0d_swait", i), s_waitrequest, 0);
            tick();
            chk($sformatf("wrb%0d_m_write", i), m_write, 1);
            chk($sformatf("wrb%0d_wdata", i), m_writedata[63:0], 64'h1000 + 64'(i));
            chk($sformatf("wrb%0d_addr", i), m_address, 48'h4000);
            chk($sformatf("wrb%0d_bc", i), m_burstcount, 5'd8);
        end
        s_write = 1'b0;
        s_read = 1'b1;
        s_burstcount = 5'd2;
        s_address = 48'h7000;
        #1;
        chk("wrb_after_swait", s_waitrequest, 0);
        tick();
        s_read = 1'b0;
        chk("wrb_after_m_read", m_read, 1);
        chk("wrb_after_outstanding", outstanding_beats, 9'd2);

        // Downstream stall: held command is stable, then issues once.
        do_reset();
        s_write = 1'b1;
        s_burstcount = 5'd1;
        s_address = 48'h55;
        s_writedata = '0;
        s_writedata[63:0] = 64'h77;
        tick();
        s_write = 1'b0;
        s_read = 1'b1;
        s_burstcount = 5'd2;
        s_address = 48'h66;
        m_waitrequest = 1'b1;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("mw%0d_swait", c), s_waitrequest, 1);
            tick();
            chk($sformatf("mw%0d_m_write", c), m_write, 1);
            chk($sformatf("mw%0d_addr", c), m_address, 48'h55);
            chk($sformatf("mw%0d_wdata", c), m_writedata[63:0], 64'h77);
        end
        m_waitrequest = 1'b0;
        #1;
        chk("mw_rel_swait", s_waitrequest, 0);
        tick();
        s_read = 1'b0;
        chk("mw_rel_m_write", m_write, 0);
        chk("mw_rel_m_read", m_read, 1);
        chk("mw_rel_addr", m_address, 48'h66);
        tick();
        chk("mw_single_m_read", m_read, 0);
        chk("mw_single_m_write", m_write, 0);
        chk("mw_outstanding", outstanding_beats, 9'd2);

        // Stale response with nothing outstanding.
        do_reset();
        m_readdatavalid = 1'b1;
        m_readdata = '0;
        m_readdata[15:0] = 16'hDEAD;
        tick();
        m_readdatavalid = 1'b0;
        chk("uf_err", err_underflow, 1);
        chk("uf_s_rdv", s_readdatavalid, 1);
        chk("uf_s_readdata", s_readdata[15:0], 16'hDEAD);
        chk("uf_outstanding", outstanding_beats, 0);
        tick();
        chk("uf_s_rdv_pulse", s_readdatavalid, 0);
        chk("uf_err_sticky", err_underflow, 1);
        chk("uf_outstanding_hold", outstanding_beats, 0);
        do_reset();
        chk("uf_err_cleared", err_underflow, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
